// File: rtl/rx_frame_sequencer_if.sv
// Beat-tag bus between the RX synchronizer valid and the LTF estimator/equalizer.
// The master side drives valid_i; the sequencer (slave) returns the registered tags.
interface rx_frame_sequencer_if #(
    parameter int BW = 4,
    parameter int SW = 4
);
    logic          valid_i;
    logic          tag_valid_o;
    logic [1:0]    seg_o;
    logic [BW-1:0] beat_o;
    logic [SW-1:0] sym_idx_o;
    logic          cp_o;
    logic          sof_o;
    logic          eof_o;
    logic          abort_o;
    logic [15:0]   pkt_cnt_o;
    logic [15:0]   abort_cnt_o;

    modport master (
        output valid_i,
        input  tag_valid_o, seg_o, beat_o, sym_idx_o, cp_o,
        input  sof_o, eof_o, abort_o, pkt_cnt_o, abort_cnt_o
    );

    modport slave (
        input  valid_i,
        output tag_valid_o, seg_o, beat_o, sym_idx_o, cp_o,
        output sof_o, eof_o, abort_o, pkt_cnt_o, abort_cnt_o
    );
endinterface

// File: rtl/rx_frame_sequencer.sv
// Packet-level RX controller: walks each packet through STF/LTF/DATA and tags
// every beat with segment, beat, symbol, CP and start/end/abort flags (one cycle late).
module rx_frame_sequencer #(
    parameter int PHASES   = 16,
    parameter int STF_LEN  = 160,
    parameter int LTF_LEN  = 160,
    parameter int FFT_SIZE = 64,
    parameter int CP_LEN   = 16,
    parameter int NUMSYMB  = 12
) (
    input logic clk_i,
    input logic rst_i,
    rx_frame_sequencer_if.slave bus
);
    localparam int SB   = STF_LEN / PHASES;
    localparam int LB   = LTF_LEN / PHASES;
    localparam int YB   = (FFT_SIZE + CP_LEN) / PHASES;
    localparam int CB   = CP_LEN / PHASES;
    localparam int MAXB = (SB > LB) ? ((SB > YB) ? SB : YB) : ((LB > YB) ? LB : YB);
    localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam int SW   = (NUMSYMB > 1) ? $clog2(NUMSYMB) : 1;

    localparam logic [BW-1:0] SB_LAST  = BW'(SB - 1);
    localparam logic [BW-1:0] LB_LAST  = BW'(LB - 1);
    localparam logic [BW-1:0] YB_LAST  = BW'(YB - 1);
    localparam logic [BW-1:0] CB_BEATS = BW'(CB);
    localparam logic [SW-1:0] SYM_LAST = SW'(NUMSYMB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STF  = 2'd1,
        S_LTF  = 2'd2,
        S_DATA = 2'd3
    } seg_e;

    seg_e          seg, nseg;
    logic [BW-1:0] beat, nbeat;
    logic [SW-1:0] sym, nsym;
    logic          armed, tag_valid, cp, sof, eof, abort;
    logic [15:0]   pkt_cnt, abort_cnt;
    logic          last_beat, take;

    // Position of the next beat if this one is accepted; IDLE starts a packet.
    always_comb begin
        nseg  = seg;
        nbeat = beat + 1'b1;
        nsym  = sym;
        case (seg)
            S_IDLE: begin
                nseg  = S_STF;
                nbeat = '0;
                nsym  = '0;
            end
            S_STF: if (beat == SB_LAST) begin
                nseg  = S_LTF;
                nbeat = '0;
            end
            S_LTF: if (beat == LB_LAST) begin
                nseg  = S_DATA;
                nbeat = '0;
                nsym  = '0;
            end
            S_DATA: if (beat == YB_LAST) begin
                nbeat = '0;
                nsym  = sym + 1'b1;
            end
            default: nseg = S_IDLE;
        endcase
    end

    // The packet's last beat has already been tagged when the state sits on it,
    // so the following valid (high or low) only decides re-arming.
    assign last_beat = (seg == S_DATA) && (beat == YB_LAST) && (sym == SYM_LAST);
    assign take      = bus.valid_i && ((seg == S_IDLE) ? armed : !last_beat);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            seg       <= S_IDLE;
            beat      <= '0;
            sym       <= '0;
            armed     <= 1'b1;
            tag_valid <= 1'b0;
            cp        <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            abort     <= 1'b0;
            pkt_cnt   <= '0;
            abort_cnt <= '0;
        end else begin
            sof   <= 1'b0;
            eof   <= 1'b0;
            abort <= 1'b0;
            if (take) begin
                seg       <= nseg;
                beat      <= nbeat;
                sym       <= nsym;
                cp        <= (nseg == S_DATA) && (nbeat < CB_BEATS);
                tag_valid <= 1'b1;
                sof       <= (seg == S_IDLE);
                if (nseg == S_DATA && nbeat == YB_LAST && nsym == SYM_LAST) begin
                    eof     <= 1'b1;
                    pkt_cnt <= pkt_cnt + 16'd1;
                end
            end else begin
                seg       <= S_IDLE;
                beat      <= '0;
                sym       <= '0;
                cp        <= 1'b0;
                tag_valid <= 1'b0;
                // Valid held high after a packet keeps us disarmed until it drops.
                armed     <= !bus.valid_i;
                if (seg != S_IDLE && !last_beat) begin
                    abort     <= 1'b1;
                    abort_cnt <= abort_cnt + 16'd1;
                end
            end
        end
    end

    assign bus.tag_valid_o = tag_valid;
    assign bus.seg_o       = seg;
    assign bus.beat_o      = beat;
    assign bus.sym_idx_o   = sym;
    assign bus.cp_o        = cp;
    assign bus.sof_o       = sof;
    assign bus.eof_o       = eof;
    assign bus.abort_o     = abort;
    assign bus.pkt_cnt_o   = pkt_cnt;
    assign bus.abort_cnt_o = abort_cnt;
endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Bench for rx_frame_sequencer: default and PHASES=8 instances share one valid,
// each checked every cycle against a packet-position reference model.
module tb_rx_frame_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic valid;

    always #5 clk = ~clk;

    rx_frame_sequencer_if #(.BW(4), .SW(4)) if0 ();
    rx_frame_sequencer_if #(.BW(5), .SW(4)) if1 ();
    assign if0.valid_i = valid;
    assign if1.valid_i = valid;

    rx_frame_sequencer u0 (.clk_i(clk), .rst_i(rst_n), .bus(if0));
    rx_frame_sequencer #(.PHASES(8)) u1 (.clk_i(clk), .rst_i(rst_n), .bus(if1));

    typedef struct {
        int sb; int lb; int yb; int cb; int ns;
    } cfg_t;

    typedef struct {
        int pos;  bit armed; int pkt; int abc;
        bit tv;   bit sof;   bit eof; bit ab; bit cp;
        int seg;  int beat;  int sym;
    } mdl_t;

    typedef struct {
        bit v; int n;
        int tv; int sof; int eof; int ab; int cp; int pkt; int abc;
    } vec_t;

    cfg_t c0 = '{10, 10, 5, 1, 12};
    cfg_t c1 = '{20, 20, 10, 2, 12};
    mdl_t m0, m1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t_tv, t_sof, t_eof, t_ab, t_cp;
    int   t1_cp, t1_eof, eof_at;
    vec_t tbl [10];

    task automatic mdl_reset(inout mdl_t m);
        m = '{-1, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    endtask

    // Packet is a flat run of beats; tags follow from the absolute position.
    task automatic mdl_step(input cfg_t c, input bit v, inout mdl_t m);
        int tot, d;
        tot   = c.sb + c.lb + c.yb * c.ns;
        m.sof = 0; m.eof = 0; m.ab = 0;
        if (m.pos == tot - 1) begin
            m.pos = -1; m.armed = !v;
        end else if (!v) begin
            if (m.pos >= 0) begin m.ab = 1; m.abc = (m.abc + 1) % 65536; end
            m.pos = -1; m.armed = 1;
        end else if (m.pos < 0) begin
            if (m.armed) begin m.pos = 0; m.sof = 1; end
        end else begin
            m.pos++;
        end
        m.tv = (m.pos >= 0);
        m.seg = 0; m.beat = 0; m.sym = 0; m.cp = 0;
        if (m.pos < 0) begin
        end else if (m.pos < c.sb) begin
            m.seg = 1; m.beat = m.pos;
        end else if (m.pos < c.sb + c.lb) begin
            m.seg = 2; m.beat = m.pos - c.sb;
        end else begin
            d = m.pos - c.sb - c.lb;
            m.seg = 3; m.sym = d / c.yb; m.beat = d % c.yb; m.cp = (m.beat < c.cb);
        end
        if (m.pos == tot - 1) begin m.eof = 1; m.pkt = (m.pkt + 1) % 65536; end
    endtask

    function automatic logic [63:0] pk(input bit tv, sof, eof, ab, cp,
                                       input int seg, beat, sym, pkt, abc);
        return {9'd0, tv, sof, eof, ab, cp, seg[1:0], beat[7:0], sym[7:0], pkt[15:0], abc[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_u0"},
            pk(if0.tag_valid_o, if0.sof_o, if0.eof_o, if0.abort_o, if0.cp_o, int'(if0.seg_o),
               int'(if0.beat_o), int'(if0.sym_idx_o), int'(if0.pkt_cnt_o), int'(if0.abort_cnt_o)),
            pk(m0.tv, m0.sof, m0.eof, m0.ab, m0.cp, m0.seg, m0.beat, m0.sym, m0.pkt, m0.abc));
        chk({tag, "_u1"},
            pk(if1.tag_valid_o, if1.sof_o, if1.eof_o, if1.abort_o, if1.cp_o, int'(if1.seg_o),
               int'(if1.beat_o), int'(if1.sym_idx_o), int'(if1.pkt_cnt_o), int'(if1.abort_cnt_o)),
            pk(m1.tv, m1.sof, m1.eof, m1.ab, m1.cp, m1.seg, m1.beat, m1.sym, m1.pkt, m1.abc));
    endtask

    // Edge with valid already applied: advance models, compare, tally pulses.
    task automatic sample(input bit v);
        @(posedge clk);
        mdl_step(c0, v, m0);
        mdl_step(c1, v, m1);
        #1;
        chk_all("cyc");
        t_tv  += int'(if0.tag_valid_o);
        t_sof += int'(if0.sof_o);
        t_eof += int'(if0.eof_o);
        t_ab  += int'(if0.abort_o);
        t_cp  += int'(if0.cp_o);
        t1_cp  += int'(if1.cp_o);
        t1_eof += int'(if1.eof_o);
    endtask

    task automatic step(input bit v);
        @(negedge clk);
        valid = v;
        sample(v);
    endtask

    task automatic clr_tally();
        t_tv = 0; t_sof = 0; t_eof = 0; t_ab = 0; t_cp = 0; t1_cp = 0; t1_eof = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        mdl_reset(m0);
        mdl_reset(m1);
        @(negedge clk);
        chk_all("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        mdl_reset(m0);
        mdl_reset(m1);
        clr_tally();

        //          v   n    tv sof eof ab cp pkt abc
        tbl[0] = '{1,  80,  80, 1, 1, 0, 12, 1, 0};  // nominal packet
        tbl[1] = '{0,   3,   0, 0, 0, 0,  0, 1, 0};
        tbl[2] = '{1,  13,  13, 1, 0, 0,  0, 1, 0};  // STF + LTF beats 0..2
        tbl[3] = '{0,   1,   0, 0, 0, 1,  0, 1, 1};  // drop on LTF beat 3
        tbl[4] = '{1, 200,  80, 1, 1, 0, 12, 2, 1};  // held valid: one packet
        tbl[5] = '{0,   1,   0, 0, 0, 0,  0, 2, 1};
        tbl[6] = '{1,  80,  80, 1, 1, 0, 12, 3, 1};  // back-to-back pair
        tbl[7] = '{0,   1,   0, 0, 0, 0,  0, 3, 1};
        tbl[8] = '{1,  80,  80, 1, 1, 0, 12, 4, 1};
        tbl[9] = '{0,   2,   0, 0, 0, 0,  0, 4, 1};

        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            clr_tally();
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].v);
            chk($sformatf("r%0d_tv", i),  64'(t_tv),  64'(tbl[i].tv));
            chk($sformatf("r%0d_sof", i), 64'(t_sof), 64'(tbl[i].sof));
            chk($sformatf("r%0d_eof", i), 64'(t_eof), 64'(tbl[i].eof));
            chk($sformatf("r%0d_ab", i),  64'(t_ab),  64'(tbl[i].ab));
            chk($sformatf("r%0d_cp", i),  64'(t_cp),  64'(tbl[i].cp));
            chk($sformatf("r%0d_pkt", i), 64'(if0.pkt_cnt_o),   64'(tbl[i].pkt));
            chk($sformatf("r%0d_abc", i), 64'(if0.abort_cnt_o), 64'(tbl[i].abc));
        end

        // Async reset during DATA sym 5; valid stays high and restarts at once.
        for (int k = 0; k < 48; k++) step(1'b1);
        chk("pre_rst_sym", 64'(if0.sym_idx_o), 64'd5);
        #1;
        rst_n = 1'b0;
        mdl_reset(m0);
        mdl_reset(m1);
        #1;
        chk_all("async_rst");
        chk("async_rst_seg", 64'(if0.seg_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sample(1'b1);
        chk("rst_rearm_sof", 64'(if0.sof_o), 64'd1);

        // PHASES=8 instance: 20+20+12x10 beats, CP on sym beats 0 and 1.
        do_reset();
        clr_tally();
        eof_at = -1;
        for (int k = 0; k < 170; k++) begin
            step(1'b1);
            if (if1.eof_o) eof_at = k;
        end
        chk("p8_eof_at", 64'(eof_at), 64'd159);
        chk("p8_eof_n",  64'(t1_eof), 64'd1);
        chk("p8_cp_n",   64'(t1_cp),  64'd24);
        chk("p8_pkt",    64'(if1.pkt_cnt_o), 64'd1);
        step(1'b0);

        // Random bursts: mostly long highs with short drops.
        for (int b = 0; b < 40; b++) begin
            int hi, lo;
            hi = $urandom_range(1, 220);
            lo = $urandom_range(1, 4);
            for (int k = 0; k < hi; k++) step(1'b1);
            for (int k = 0; k < lo; k++) step(1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
